// File: rtl/run_mon_pkg.sv
// Shared types and helpers for the simulation run monitor.
//   run_state_t : run-controller state encoding.
//   popcount()  : number of set bits in a lane mask of up to POP_MAX_LANES lanes.
package run_mon_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2,
        TIMEOUT    = 2'd3
    } run_state_t;

    // Widest commit-lane mask the popcount helper accepts; callers zero-extend.
    localparam int POP_MAX_LANES = 32;
    localparam int POP_W         = $clog2(POP_MAX_LANES + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_LANES-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_LANES; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/commit_lane_reduce.sv
// Combinational reduction of the per-lane commit bus for one cycle.
// Ports:
//   commit_valid_i : per-lane retire valid (lane 0 oldest)
//   commit_halt_i  : per-lane halt marker
//   commit_pc_i    : per-lane PC, lane i at [i*PC_W +: PC_W]
//   halt_found_o   : some valid lane carries a halt marker
//   halt_pc_o      : PC of the oldest such lane
//   retire_cnt_o   : valid lanes up to and including the halt lane (all valid lanes if none)
//   any_valid_o    : at least one lane valid
//   young_pc_o     : PC of the youngest valid lane
module commit_lane_reduce
    import run_mon_pkg::*;
#(
    parameter int LANES = 2,
    parameter int PC_W  = 32
) (
    input  logic [LANES-1:0]      commit_valid_i,
    input  logic [LANES-1:0]      commit_halt_i,
    input  logic [LANES*PC_W-1:0] commit_pc_i,
    output logic                  halt_found_o,
    output logic [PC_W-1:0]       halt_pc_o,
    output logic [POP_W-1:0]      retire_cnt_o,
    output logic                  any_valid_o,
    output logic [PC_W-1:0]       young_pc_o
);

    logic [LANES-1:0] keep;
    logic             seen;

    always_comb begin
        halt_found_o = 1'b0;
        halt_pc_o    = '0;
        any_valid_o  = 1'b0;
        young_pc_o   = '0;
        keep         = '0;
        seen         = 1'b0;
        // Walk oldest to youngest: lanes after the first halt are squashed.
        for (int i = 0; i < LANES; i++) begin
            if (!seen) begin
                keep[i] = commit_valid_i[i];
            end
            if (commit_valid_i[i]) begin
                any_valid_o = 1'b1;
                young_pc_o  = commit_pc_i[i*PC_W +: PC_W];
            end
            if (!seen && commit_valid_i[i] && commit_halt_i[i]) begin
                seen         = 1'b1;
                halt_found_o = 1'b1;
                halt_pc_o    = commit_pc_i[i*PC_W +: PC_W];
            end
        end
    end

    assign retire_cnt_o = popcount(POP_MAX_LANES'(keep));

endmodule

// File: rtl/sim_run_monitor.sv
// Run controller beside the core: sequences core reset, counts RUN cycles and
// retired instructions, detects completion (halt commit or PC self-loop) and
// enforces a cycle budget.
// Ports:
//   clk, rst (async, active-high), start (restart from DONE/TIMEOUT)
//   commit_valid/commit_pc/commit_halt : per-lane commit bus from the core
//   core_rst_n : active-low core reset, low only in RESET_HOLD
//   running/done/timeout : state decodes
//   cycle_cnt, instret_cnt : RUN cycles and retired instructions
//   halt_pc : PC at which completion was detected
module sim_run_monitor
    import run_mon_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int MAX_CYCLES  = 1500,
    parameter int LOOP_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LANES-1:0]      commit_valid,
    input  logic [LANES*PC_W-1:0] commit_pc,
    input  logic [LANES-1:0]      commit_halt,
    output logic                  core_rst_n,
    output logic                  running,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret_cnt,
    output logic [PC_W-1:0]       halt_pc
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LOOP_W = $clog2(LOOP_THRESH + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_MAX  = LOOP_W'(LOOP_THRESH);

    run_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic              loop_hit;

    logic              red_halt_found;
    logic [PC_W-1:0]   red_halt_pc;
    logic [POP_W-1:0]  red_retire_cnt;
    logic              red_any_valid;
    logic [PC_W-1:0]   red_young_pc;

    commit_lane_reduce #(
        .LANES (LANES),
        .PC_W  (PC_W)
    ) u_reduce (
        .commit_valid_i (commit_valid),
        .commit_halt_i  (commit_halt),
        .commit_pc_i    (commit_pc),
        .halt_found_o   (red_halt_found),
        .halt_pc_o      (red_halt_pc),
        .retire_cnt_o   (red_retire_cnt),
        .any_valid_o    (red_any_valid),
        .young_pc_o     (red_young_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_HOLD;
            hold_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            halt_pc_q <= '0;
            last_pc_q <= '0;
            loop_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            halt_pc_q <= halt_pc_d;
            last_pc_q <= last_pc_d;
            loop_q    <= loop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        halt_pc_d = halt_pc_q;
        last_pc_d = last_pc_q;
        loop_d    = loop_q;
        loop_hit  = 1'b0;

        case (state_q)
            RESET_HOLD: begin
                cycle_d   = '0;
                instret_d = '0;
                halt_pc_d = '0;
                loop_d    = '0;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            RUN: begin
                cycle_d   = cycle_q + CNT_W'(1);
                instret_d = instret_q + CNT_W'(red_retire_cnt);
                // Idle cycles leave the loop detector untouched.
                if (red_any_valid) begin
                    last_pc_d = red_young_pc;
                    if (red_young_pc == last_pc_q) begin
                        loop_d = (loop_q == LOOP_MAX) ? loop_q : loop_q + LOOP_W'(1);
                    end else begin
                        loop_d = '0;
                    end
                    loop_hit = (loop_d == LOOP_MAX);
                end
                // Completion outranks the budget check in the same cycle.
                if (red_halt_found) begin
                    halt_pc_d = red_halt_pc;
                    state_d   = DONE;
                end else if (loop_hit) begin
                    halt_pc_d = red_young_pc;
                    state_d   = DONE;
                end else if (cycle_q == CYC_LAST) begin
                    state_d = TIMEOUT;
                end
            end

            DONE, TIMEOUT: begin
                if (start) begin
                    state_d   = RESET_HOLD;
                    hold_d    = '0;
                    cycle_d   = '0;
                    instret_d = '0;
                    halt_pc_d = '0;
                    loop_d    = '0;
                end
            end

            default: begin
                state_d = RESET_HOLD;
                hold_d  = '0;
            end
        endcase
    end

    assign core_rst_n  = (state_q != RESET_HOLD);
    assign running     = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign timeout     = (state_q == TIMEOUT);
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign halt_pc     = halt_pc_q;

endmodule
